// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and data requesters share one split-transaction
// memory port; data wins in IDLE and a completing owner hands off to the other side.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic        r_owner;
  logic [7:0]  r_wait;
  logic        r_bus_err;
  logic        r_mem_req;
  logic        r_mem_wr;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_done;
  logic        w_free;
  logic        w_grant_d;
  logic        w_grant_i;
  logic [7:0]  w_wait_inc;

  assign w_done     = (r_state == S_DATA) && mem_data_ok;
  assign w_free     = (r_state == S_IDLE) || w_done;
  // The completing owner is excluded so the other side gets the port next.
  assign w_grant_d  = w_free && data_req && !(w_done && r_owner);
  assign w_grant_i  = w_free && inst_req && !w_grant_d && !(w_done && !r_owner);
  assign w_wait_inc = (r_wait == 8'hFF) ? 8'hFF : r_wait + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_wait      <= 8'd0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wstrb <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else if (w_grant_d) begin
      r_state     <= S_ADDR;
      r_owner     <= 1'b1;
      r_mem_req   <= 1'b1;
      r_mem_wr    <= data_wr;
      r_mem_wstrb <= data_wr ? data_wstrb : 4'd0;
      r_mem_addr  <= data_addr;
      r_mem_wdata <= data_wdata;
    end else if (w_grant_i) begin
      r_state     <= S_ADDR;
      r_owner     <= 1'b0;
      r_mem_req   <= 1'b1;
      r_mem_wr    <= 1'b0;
      r_mem_wstrb <= 4'd0;
      r_mem_addr  <= inst_addr;
      r_mem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_ADDR: if (mem_addr_ok) begin
          r_state   <= S_DATA;
          r_mem_req <= 1'b0;
          r_wait    <= 8'd0;
        end
        S_DATA: if (mem_data_ok) begin
          r_state <= S_IDLE;
        end else begin
          // Slow slave is only flagged; the transaction keeps waiting.
          r_wait <= w_wait_inc;
          if (w_wait_inc >= LP_TIMEOUT) r_bus_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_wr       = r_mem_wr;
  assign mem_wstrb    = r_mem_wstrb;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign bus_err      = r_bus_err;
  assign inst_data_ok = w_done && !r_owner;
  assign data_data_ok = w_done &&  r_owner;
  assign inst_rdata   = (w_done && !r_owner) ? mem_rdata : 32'd0;
  assign data_rdata   = (w_done &&  r_owner) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted slave, transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        inst_data_ok, data_data_ok, mem_req, mem_wr, bus_err;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scripted slave: addr_ok after a_wait refused cycles, data_ok after d_wait idle DATA cycles.
  int          a_wait = 0, d_wait = 0;
  logic [31:0] slv_rdata = 32'd0;
  int          s_acnt = 0, s_dcnt = 0;
  bit          s_in_data = 0;

  always begin
    @(posedge clk); #1;
    if (!rst) begin
      s_acnt = 0; s_dcnt = 0; s_in_data = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    end else begin
      if (mem_addr_ok) begin s_in_data = 1; s_dcnt = 0; end
      if (mem_data_ok) s_in_data = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      if (mem_req) begin
        if (s_acnt == a_wait) begin mem_addr_ok = 1; s_acnt = 0; end
        else s_acnt++;
      end else if (s_in_data) begin
        if (s_dcnt == d_wait) begin mem_data_ok = 1; mem_rdata = slv_rdata; end
        else s_dcnt++;
      end
    end
  end

  // Reference model: one current transaction, its address-phase status and wait count.
  logic        m_busy, m_acc, m_isd, m_err;
  logic [7:0]  m_wait;
  logic        m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_free, m_pick_d, m_pick_i, m_done;

  assign m_done   = m_busy && m_acc && mem_data_ok;
  assign m_free   = !m_busy || m_done;
  assign m_pick_d = m_free && data_req && (m_busy ? !m_isd : 1'b1);
  assign m_pick_i = m_free && inst_req && (m_busy ? m_isd : !data_req);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_acc <= 0; m_isd <= 0; m_err <= 0; m_wait <= 0;
      m_wr <= 0; m_wstrb <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (m_pick_d) begin
      m_busy <= 1; m_acc <= 0; m_isd <= 1;
      m_wr <= data_wr; m_wstrb <= data_wr ? data_wstrb : 4'd0;
      m_addr <= data_addr; m_wdata <= data_wdata;
    end else if (m_pick_i) begin
      m_busy <= 1; m_acc <= 0; m_isd <= 0;
      m_wr <= 0; m_wstrb <= 0; m_addr <= inst_addr; m_wdata <= 0;
    end else if (m_done) begin
      m_busy <= 0;
    end else if (m_busy && !m_acc) begin
      if (mem_addr_ok) begin m_acc <= 1; m_wait <= 0; end
    end else if (m_busy) begin
      m_wait <= (m_wait == 8'hFF) ? 8'hFF : m_wait + 8'd1;
      if (int'(m_wait) + 1 >= int'(TO)) m_err <= 1;
    end
  end

  always @(negedge clk) begin
    chk("mem_req",      {31'd0, mem_req},      {31'd0, m_busy && !m_acc});
    chk("mem_wr",       {31'd0, mem_wr},       {31'd0, m_wr});
    chk("mem_wstrb",    {28'd0, mem_wstrb},    {28'd0, m_wstrb});
    chk("mem_addr",     mem_addr,              m_addr);
    chk("mem_wdata",    mem_wdata,             m_wdata);
    chk("bus_err",      {31'd0, bus_err},      {31'd0, m_err});
    chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, m_done && !m_isd});
    chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, m_done && m_isd});
    chk("inst_rdata",   inst_rdata,            (m_done && !m_isd) ? mem_rdata : 32'd0);
    chk("data_rdata",   data_rdata,            (m_done && m_isd) ? mem_rdata : 32'd0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) step();
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1;
    step();

    // Single fetch
    slv_rdata = 32'h3C08BFAF;
    inst_req = 1; inst_addr = 32'hBFC00000;
    @(negedge clk); chk("t1 no early req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("t1 mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1 mem_addr", mem_addr, 32'hBFC00000);
    chk("t1 mem_wr", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    chk("t1 inst_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1 inst_rdata", inst_rdata, 32'h3C08BFAF);
    chk("t1 data_ok", {31'd0, data_data_ok}, 32'd0);
    step(); inst_req = 0;
    repeat (2) step();

    // Simultaneous requests: data store first, then fetch back-to-back
    slv_rdata = 32'h0000_1111;
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011;
    data_addr = 32'h80001000; data_wdata = 32'h12345678;
    @(negedge clk); @(negedge clk);
    chk("t2 mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t2 mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
    chk("t2 mem_addr", mem_addr, 32'h80001000);
    chk("t2 mem_wdata", mem_wdata, 32'h12345678);
    @(negedge clk);
    chk("t2 data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t2 inst_ok early", {31'd0, inst_data_ok}, 32'd0);
    step(); data_req = 0; data_wr = 0; data_wstrb = 0;
    @(negedge clk);
    chk("t2 b2b mem_req", {31'd0, mem_req}, 32'd1);
    chk("t2 b2b mem_addr", mem_addr, 32'hBFC00004);
    chk("t2 b2b mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
    @(negedge clk);
    chk("t2 inst_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t2 inst_rdata", inst_rdata, 32'h0000_1111);
    step(); inst_req = 0;
    repeat (2) step();

    // Owner exclusion: data load held high through its completion
    slv_rdata = 32'hA5A5_0001;
    data_req = 1; data_wr = 0; data_wstrb = 4'hF; data_addr = 32'h80002000; data_wdata = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("t3 load wstrb", {28'd0, mem_wstrb}, 32'h0);
    @(negedge clk);
    chk("t3 data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t3 data_rdata", data_rdata, 32'hA5A5_0001);
    @(negedge clk);
    chk("t3 idle gap", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("t3 regrant", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    chk("t3 data_ok 2", {31'd0, data_data_ok}, 32'd1);
    step(); data_req = 0; data_wstrb = 0;
    repeat (2) step();

    // Slave stalls
    begin
      int req_cnt = 0;
      int done_at = -1;
      a_wait = 4; d_wait = 6; slv_rdata = 32'h0BAD_CAFE;
      data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h80004000; data_wdata = 32'hDEAD_BEEF;
      for (int i = 0; i <= 12; i++) begin
        @(negedge clk);
        if (mem_req) req_cnt++;
        if (data_data_ok && done_at < 0) done_at = i;
      end
      step(); data_req = 0; data_wr = 0; data_wstrb = 0;
      chk("t4 mem_req cycles", req_cnt, 32'd5);
      chk("t4 done cycle", done_at, 32'd12);
      chk("t4 bus_err", {31'd0, bus_err}, 32'd0);
      a_wait = 0; d_wait = 0;
      repeat (2) step();
    end

    // Timeout with TIMEOUT=8, data_ok withheld for 10 DATA cycles
    d_wait = 10; slv_rdata = 32'h7777_0000;
    inst_req = 1; inst_addr = 32'hBFC00200;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i == 9)  chk("t5 err before", {31'd0, bus_err}, 32'd0);
      if (i == 10) chk("t5 err set", {31'd0, bus_err}, 32'd1);
      if (i == 12) begin
        chk("t5 inst_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("t5 inst_rdata", inst_rdata, 32'h7777_0000);
      end
    end
    step(); inst_req = 0; d_wait = 0;
    repeat (3) step();
    chk("t5 err sticky", {31'd0, bus_err}, 32'd1);

    // Mid-transaction reset during DATA
    d_wait = 5;
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h80003000; data_wdata = 32'hCAFEF00D;
    repeat (3) step();
    #2 rst = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    #1;
    chk("t6 mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6 mem_addr", mem_addr, 32'd0);
    chk("t6 mem_wdata", mem_wdata, 32'd0);
    chk("t6 mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("t6 bus_err", {31'd0, bus_err}, 32'd0);
    repeat (2) step();
    rst = 1; d_wait = 0; slv_rdata = 32'h2402_0001;
    step();
    inst_req = 1; inst_addr = 32'hBFC00100;
    @(negedge clk); @(negedge clk);
    chk("t6 fresh mem_addr", mem_addr, 32'hBFC00100);
    @(negedge clk);
    chk("t6 fresh inst_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t6 fresh rdata", inst_rdata, 32'h2402_0001);
    step(); inst_req = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
